uart_cmd_rcv: RTL

UART_CMD_RCV -- requirements
Module: uart_cmd_rcv

---
 rtl/uart_cmd_rcv_if.sv | 13 +
 rtl/uart_cmd_rcv.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_cmd_rcv_if.sv
// uart_cmd_rcv_if: serial lines plus command/response handshake of uart_cmd_rcv
interface uart_cmd_rcv_if;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  modport master (output RX, clr_cmd_rdy, resp, send_resp, input TX, cmd, cmd_rdy, resp_sent);
  modport slave  (input RX, clr_cmd_rdy, resp, send_resp, output TX, cmd, cmd_rdy, resp_sent);
endinterface

// File: rtl/uart_cmd_rcv.sv
// uart_cmd_rcv: 8N1 UART receiving two-byte commands and transmitting one-byte responses.
// Define INTERBYTE_TIMEOUT_EN to drop a lone MSB after TIMEOUT_CYC idle clocks.
module uart_cmd_rcv #(
  parameter int BAUD_DIV    = 5208,
  parameter int TIMEOUT_CYC = 2000000
) (
  input logic clk,
  input logic rst_n,
  uart_cmd_rcv_if.slave u
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam int AW = $clog2(10 * BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] SAMP = CW'(BAUD_DIV / 2 - 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(10 * BAUD_DIV - 1);
  if (BAUD_DIV < 4 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("uart_cmd_rcv: BAUD_DIV must be >= 4 and TIMEOUT_CYC >= 2");
  end
  typedef enum logic {A_IDLE, A_WAIT_LSB} asm_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_t;
  logic rx1_q, rx1_d, rx2_q, rx2_d, rx3_q, rx3_d;
  logic armed_q, armed_d;
  logic [AW-1:0] arm_cnt_q, arm_cnt_d;
  logic rx_busy_q, rx_busy_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  asm_t asm_q, asm_d;
  logic [7:0] msb_q, msb_d;
  logic [15:0] cmd_q, cmd_d;
  logic rdy_q, rdy_d;
  tx_t tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_dat_q, tx_dat_d;
  logic tx_q, tx_d, sent_q, sent_d;
  logic rx_start, rx_samp, rx_stop, good, bad, done, to_hit, tx_acc, tx_end;
`ifdef INTERBYTE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic to_run;
`endif
  always_comb begin
    rx1_d = u.RX;
    rx2_d = rx1_q;
    rx3_d = rx2_q;
    // Receiver stays disarmed after reset until the line has been high longer than any frame can be
    arm_cnt_d = armed_q ? arm_cnt_q : (rx2_q ? arm_cnt_q + 1'b1 : '0);
    armed_d = armed_q | (rx2_q && arm_cnt_q == ARM_LAST);
    rx_start = rx3_q & ~rx2_q & armed_q & ~rx_busy_q;
    rx_samp = rx_busy_q && rx_cnt_q == SAMP;
    rx_stop = rx_samp && rx_bit_q == 4'd9;
    rx_busy_d = rx_start | (rx_busy_q & ~rx_stop);
    rx_cnt_d = (rx_busy_q && !rx_stop && rx_cnt_q != LAST) ? rx_cnt_q + 1'b1 : '0;
    rx_bit_d = (!rx_busy_q || rx_stop) ? 4'd0 : (rx_cnt_q == LAST ? rx_bit_q + 1'b1 : rx_bit_q);
    rx_sh_d = (rx_samp && rx_bit_q != 4'd0 && !rx_stop) ? {rx2_q, rx_sh_q[7:1]} : rx_sh_q;
    good = rx_stop & rx2_q;
    bad = rx_stop & ~rx2_q;
    done = good && asm_q == A_WAIT_LSB;
`ifdef INTERBYTE_TIMEOUT_EN
    to_run = asm_q == A_WAIT_LSB && !rx_busy_q && !rx_start;
    to_hit = to_run && to_cnt_q == TO_LAST;
    to_cnt_d = (to_run && !to_hit) ? to_cnt_q + 1'b1 : '0;
`else
    to_hit = 1'b0;
`endif
    asm_d = (bad || to_hit) ? A_IDLE : good ? (asm_q == A_IDLE ? A_WAIT_LSB : A_IDLE) : asm_q;
    msb_d = to_hit ? 8'h00 : (good && asm_q == A_IDLE) ? rx_sh_q : msb_q;
    cmd_d = done ? {msb_q, rx_sh_q} : cmd_q;
    rdy_d = done | (rdy_q & ~u.clr_cmd_rdy & ~(rx_start && asm_q == A_IDLE));
    tx_acc = tx_st_q == T_IDLE && u.send_resp;
    tx_end = tx_cnt_q == LAST;
    tx_cnt_d = (tx_st_q == T_IDLE || tx_end) ? '0 : tx_cnt_q + 1'b1;
    tx_dat_d = tx_acc ? u.resp : tx_dat_q;
    tx_bit_d = (tx_st_q == T_DATA && tx_end) ? tx_bit_q + 1'b1 : tx_bit_q;
    tx_st_d = tx_acc ? T_START : !tx_end ? tx_st_q : tx_st_q == T_START ? T_DATA :
              tx_st_q == T_DATA ? (tx_bit_q == 3'd7 ? T_STOP : T_DATA) : T_IDLE;
    tx_d = tx_st_d == T_START ? 1'b0 : tx_st_d == T_DATA ? tx_dat_d[tx_bit_d] : 1'b1;
    sent_d = (tx_st_q == T_STOP && tx_end) | (sent_q & ~tx_acc);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx1_q <= 1'b1;
      rx2_q <= 1'b1;
      rx3_q <= 1'b1;
      armed_q <= 1'b0;
      arm_cnt_q <= '0;
      rx_busy_q <= 1'b0;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      asm_q <= A_IDLE;
      msb_q <= '0;
      cmd_q <= '0;
      rdy_q <= 1'b0;
      tx_st_q <= T_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_dat_q <= '0;
      tx_q <= 1'b1;
      sent_q <= 1'b0;
`ifdef INTERBYTE_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      rx1_q <= rx1_d;
      rx2_q <= rx2_d;
      rx3_q <= rx3_d;
      armed_q <= armed_d;
      arm_cnt_q <= arm_cnt_d;
      rx_busy_q <= rx_busy_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      asm_q <= asm_d;
      msb_q <= msb_d;
      cmd_q <= cmd_d;
      rdy_q <= rdy_d;
      tx_st_q <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_dat_q <= tx_dat_d;
      tx_q <= tx_d;
      sent_q <= sent_d;
`ifdef INTERBYTE_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end
  assign u.TX = tx_q;
  assign u.cmd = cmd_q;
  assign u.cmd_rdy = rdy_q;
  assign u.resp_sent = sent_q;
endmodule
